riscv_core_mem_t: RTL and testbench

RISCV_CORE_MEM_T -- requirements
Module: riscv_core_mem_t

---
 rtl/riscv_core_pkg.sv | 50 +++++
 rtl/riscv_core_mem_t_if.sv | 21 ++
 rtl/riscv_core_mem_t_align.sv | 45 ++++
 rtl/riscv_core_mem_t.sv | 230 +++++++++++++++++++++++
 tb/tb_riscv_core_mem_t.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_core_pkg.sv
// Shared encodings for the RISC-V core memory stage: memop/size codes,
// exception causes, FSM states, bus timeout default and alignment helpers.
package riscv_core_pkg;

  localparam int unsigned ACK_TIMEOUT_DEFAULT = 32'd255;

  typedef enum logic [1:0] {
    MEMOP_NONE  = 2'd0,
    MEMOP_LOAD  = 2'd1,
    MEMOP_STORE = 2'd2,
    MEMOP_RSVD  = 2'd3
  } memop_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    EXC_LD_MISALIGN = 2'd0,
    EXC_ST_MISALIGN = 2'd1,
    EXC_LD_BUSERR   = 2'd2,
    EXC_ST_BUSERR   = 2'd3
  } exc_cause_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_HALF: is_misaligned = lo[0];
      SIZE_WORD: is_misaligned = (lo != 2'b00);
      default:   is_misaligned = 1'b0;
    endcase
  endfunction

  // Misaligned halves/words are silently rounded down to their natural boundary.
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_HALF: align_lo = {lo[1], 1'b0};
      SIZE_WORD: align_lo = 2'b00;
      default:   align_lo = lo;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_mem_t_if.sv
// Data-bus interface between the memory stage (master) and the data memory (slave).
interface riscv_core_mem_t_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic        dbus_err;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_ack, dbus_err, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_ack, dbus_err, dbus_rdata
  );
endinterface

// File: rtl/riscv_core_mem_t_align.sv
// Byte-lane logic for the memory stage: byte enables, store replication
// and load lane extraction with sign/zero extension.
module riscv_core_mem_align_t
  import riscv_core_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  lane_b_s;
  logic [15:0] lane_h_s;

  // Lane steering for both directions of the access.
  always_comb begin
    lane_b_s = rdata[{lo, 3'b000} +: 8];
    lane_h_s = lo[1] ? rdata[31:16] : rdata[15:0];
    be       = 4'b1111;
    wdata    = st_data;
    ld_data  = rdata;
    case (size)
      SIZE_BYTE: begin
        be      = 4'b0001 << lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = is_unsigned ? {24'd0, lane_b_s} : {{24{lane_b_s[7]}}, lane_b_s};
      end
      SIZE_HALF: begin
        be      = 4'b0011 << lo;
        wdata   = {2{st_data[15:0]}};
        ld_data = is_unsigned ? {16'd0, lane_h_s} : {{16{lane_h_s[15]}}, lane_h_s};
      end
      default: begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/riscv_core_mem_t.sv
// RISC-V MEM pipeline stage: issues loads/stores on the data bus, stalls until
// ack, times out to a bus error. Optional RISCV_MEM_MISALIGN_TRAP_EN traps misalignment.
module riscv_core_mem_t
  import riscv_core_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        r_mem_valid,
  input  logic [31:0] r_mem_alu_Q,
  input  logic [31:0] r_mem_rs2_Q,
  input  logic [31:0] r_mem_pc_Q,
  input  logic [4:0]  r_mem_rd_Q,
  input  logic        r_mem_regwrite_Q,
  input  logic [1:0]  r_mem_rfwt_sel_Q,
  input  logic [1:0]  r_mem_memop_Q,
  input  logic [1:0]  r_mem_size_Q,
  input  logic        r_mem_unsigned_Q,
  input  logic        mem_flush,
  riscv_core_mem_t_if.master dbus,
  output logic [31:0] r_wb_alu_Q,
  output logic [31:0] r_wb_memdat_Q,
  output logic [31:0] r_wb_pc_Q,
  output logic [4:0]  r_wb_rd_Q,
  output logic        r_wb_regwrite_Q,
  output logic [1:0]  r_wb_rfwt_sel_Q,
  output logic        r_wb_valid_Q,
  output logic        s_mem_stall,
  output logic        mem_exc_valid,
  output logic [1:0]  mem_exc_cause,
  output logic [31:0] mem_exc_addr
);

  localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

  mem_state_e  state_r;
  logic [7:0]  cnt_r, cnt_next_s;
  logic        kill_r, kill_eff_s;
  logic [31:0] lat_alu_r, lat_rs2_r, lat_pc_r;
  logic [4:0]  lat_rd_r;
  logic        lat_rw_r, lat_we_r, lat_uns_r;
  logic [1:0]  lat_sel_r, lat_size_r, lat_lo_r;

  logic [31:0] cur_alu_s, cur_rs2_s, cur_pc_s;
  logic [4:0]  cur_rd_s;
  logic        cur_rw_s, cur_we_s, cur_uns_s;
  logic [1:0]  cur_sel_s, cur_size_s, cur_lo_s, eff_lo_s;
  logic        is_ldst_s, mis_s, req_raw_s, req_s, ack_s, stall_s, timeout_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, ld_data_s;

  // Select the live slot (IDLE) or the latched transaction (BUSY) and derive handshake.
  always_comb begin
    is_ldst_s = (r_mem_memop_Q == MEMOP_LOAD) || (r_mem_memop_Q == MEMOP_STORE);
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    eff_lo_s  = r_mem_alu_Q[1:0];
    mis_s     = r_mem_valid && !mem_flush && is_ldst_s &&
                is_misaligned(r_mem_size_Q, r_mem_alu_Q[1:0]);
`else
    eff_lo_s  = align_lo(r_mem_size_Q, r_mem_alu_Q[1:0]);
    mis_s     = 1'b0;
`endif
    if (state_r == ST_BUSY) begin
      cur_alu_s  = lat_alu_r;
      cur_rs2_s  = lat_rs2_r;
      cur_pc_s   = lat_pc_r;
      cur_rd_s   = lat_rd_r;
      cur_rw_s   = lat_rw_r;
      cur_sel_s  = lat_sel_r;
      cur_we_s   = lat_we_r;
      cur_size_s = lat_size_r;
      cur_lo_s   = lat_lo_r;
      cur_uns_s  = lat_uns_r;
      req_raw_s  = 1'b1;
      kill_eff_s = kill_r || mem_flush;
    end else begin
      cur_alu_s  = r_mem_alu_Q;
      cur_rs2_s  = r_mem_rs2_Q;
      cur_pc_s   = r_mem_pc_Q;
      cur_rd_s   = r_mem_rd_Q;
      cur_rw_s   = r_mem_regwrite_Q;
      cur_sel_s  = r_mem_rfwt_sel_Q;
      cur_we_s   = (r_mem_memop_Q == MEMOP_STORE);
      cur_size_s = r_mem_size_Q;
      cur_lo_s   = eff_lo_s;
      cur_uns_s  = r_mem_unsigned_Q;
      req_raw_s  = r_mem_valid && !mem_flush && is_ldst_s && !mis_s;
      kill_eff_s = 1'b0;
    end
    // Reset gates the request immediately, before the async state clear settles.
    req_s      = RST && req_raw_s;
    ack_s      = req_s && dbus.dbus_ack;
    stall_s    = req_s && !dbus.dbus_ack;
    cnt_next_s = cnt_r + 8'd1;
    timeout_s  = stall_s && (cnt_next_s == TMO);
  end

  riscv_core_mem_align_t u_align (
    .size        (cur_size_s),
    .lo          (cur_lo_s),
    .is_unsigned (cur_uns_s),
    .st_data     (cur_rs2_s),
    .rdata       (dbus.dbus_rdata),
    .be          (be_s),
    .wdata       (wdata_s),
    .ld_data     (ld_data_s)
  );

  assign dbus.dbus_req   = req_s;
  assign dbus.dbus_we    = cur_we_s;
  assign dbus.dbus_addr  = {cur_alu_s[31:2], 2'b00};
  assign dbus.dbus_be    = be_s;
  assign dbus.dbus_wdata = wdata_s;
  assign s_mem_stall     = stall_s;

  // Transaction FSM, WB pipeline register and exception reporting.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r         <= ST_IDLE;
      cnt_r           <= 8'd0;
      kill_r          <= 1'b0;
      lat_alu_r       <= 32'd0;
      lat_rs2_r       <= 32'd0;
      lat_pc_r        <= 32'd0;
      lat_rd_r        <= 5'd0;
      lat_rw_r        <= 1'b0;
      lat_sel_r       <= 2'd0;
      lat_we_r        <= 1'b0;
      lat_size_r      <= 2'd0;
      lat_lo_r        <= 2'd0;
      lat_uns_r       <= 1'b0;
      r_wb_alu_Q      <= 32'd0;
      r_wb_memdat_Q   <= 32'd0;
      r_wb_pc_Q       <= 32'd0;
      r_wb_rd_Q       <= 5'd0;
      r_wb_regwrite_Q <= 1'b0;
      r_wb_rfwt_sel_Q <= 2'd0;
      r_wb_valid_Q    <= 1'b0;
      mem_exc_valid   <= 1'b0;
      mem_exc_cause   <= 2'd0;
      mem_exc_addr    <= 32'd0;
    end else begin
      mem_exc_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (stall_s && !timeout_s) begin
            state_r    <= ST_BUSY;
            cnt_r      <= cnt_next_s;
            kill_r     <= 1'b0;
            lat_alu_r  <= r_mem_alu_Q;
            lat_rs2_r  <= r_mem_rs2_Q;
            lat_pc_r   <= r_mem_pc_Q;
            lat_rd_r   <= r_mem_rd_Q;
            lat_rw_r   <= r_mem_regwrite_Q;
            lat_sel_r  <= r_mem_rfwt_sel_Q;
            lat_we_r   <= cur_we_s;
            lat_size_r <= r_mem_size_Q;
            lat_lo_r   <= eff_lo_s;
            lat_uns_r  <= r_mem_unsigned_Q;
          end else begin
            cnt_r  <= 8'd0;
            kill_r <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (ack_s || timeout_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            kill_r  <= 1'b0;
          end else begin
            cnt_r  <= cnt_next_s;
            kill_r <= kill_eff_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 8'd0;
          kill_r  <= 1'b0;
        end
      endcase

      r_wb_alu_Q      <= cur_alu_s;
      r_wb_pc_Q       <= cur_pc_s;
      r_wb_rd_Q       <= cur_rd_s;
      r_wb_rfwt_sel_Q <= cur_sel_s;
      if (stall_s) begin
        r_wb_valid_Q    <= 1'b0;
        r_wb_regwrite_Q <= 1'b0;
        r_wb_memdat_Q   <= 32'd0;
        if (timeout_s && !kill_eff_s) begin
          mem_exc_valid <= 1'b1;
          mem_exc_cause <= cur_we_s ? EXC_ST_BUSERR : EXC_LD_BUSERR;
          mem_exc_addr  <= cur_alu_s;
        end else begin
          mem_exc_valid <= 1'b0;
        end
      end else if (ack_s) begin
        if (dbus.dbus_err) begin
          r_wb_valid_Q    <= 1'b0;
          r_wb_regwrite_Q <= 1'b0;
          r_wb_memdat_Q   <= 32'd0;
          mem_exc_valid   <= !kill_eff_s;
          mem_exc_cause   <= cur_we_s ? EXC_ST_BUSERR : EXC_LD_BUSERR;
          mem_exc_addr    <= cur_alu_s;
        end else begin
          r_wb_valid_Q    <= !kill_eff_s;
          r_wb_regwrite_Q <= cur_rw_s && !kill_eff_s;
          r_wb_memdat_Q   <= cur_we_s ? 32'd0 : ld_data_s;
        end
      end else if (mis_s) begin
        r_wb_valid_Q    <= 1'b0;
        r_wb_regwrite_Q <= 1'b0;
        r_wb_memdat_Q   <= 32'd0;
        mem_exc_valid   <= 1'b1;
        mem_exc_cause   <= (r_mem_memop_Q == MEMOP_STORE) ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
        mem_exc_addr    <= r_mem_alu_Q;
      end else if ((state_r == ST_IDLE) && r_mem_valid && !mem_flush && !is_ldst_s) begin
        r_wb_valid_Q    <= 1'b1;
        r_wb_regwrite_Q <= r_mem_regwrite_Q;
        r_wb_memdat_Q   <= 32'd0;
      end else begin
        r_wb_valid_Q    <= 1'b0;
        r_wb_regwrite_Q <= 1'b0;
        r_wb_memdat_Q   <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_mem_t.sv
// Self-checking bench for riscv_core_mem_t; honours RISCV_MEM_MISALIGN_TRAP_EN when defined.
module tb_riscv_core_mem_t;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        r_mem_valid = 1'b0;
  logic [31:0] r_mem_alu_Q = 32'd0, r_mem_rs2_Q = 32'd0, r_mem_pc_Q = 32'd0;
  logic [4:0]  r_mem_rd_Q = 5'd0;
  logic        r_mem_regwrite_Q = 1'b0;
  logic [1:0]  r_mem_rfwt_sel_Q = 2'd0, r_mem_memop_Q = 2'd0, r_mem_size_Q = 2'd0;
  logic        r_mem_unsigned_Q = 1'b0;
  logic        mem_flush = 1'b0;
  logic [31:0] r_wb_alu_Q, r_wb_memdat_Q, r_wb_pc_Q;
  logic [4:0]  r_wb_rd_Q;
  logic        r_wb_regwrite_Q, r_wb_valid_Q;
  logic [1:0]  r_wb_rfwt_sel_Q;
  logic        s_mem_stall, mem_exc_valid;
  logic [1:0]  mem_exc_cause;
  logic [31:0] mem_exc_addr;

  int n_chk = 0;
  int n_fail = 0;

  riscv_core_mem_t_if bus ();

  riscv_core_mem_t #(.ACK_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .r_mem_valid(r_mem_valid), .r_mem_alu_Q(r_mem_alu_Q), .r_mem_rs2_Q(r_mem_rs2_Q),
    .r_mem_pc_Q(r_mem_pc_Q), .r_mem_rd_Q(r_mem_rd_Q), .r_mem_regwrite_Q(r_mem_regwrite_Q),
    .r_mem_rfwt_sel_Q(r_mem_rfwt_sel_Q), .r_mem_memop_Q(r_mem_memop_Q),
    .r_mem_size_Q(r_mem_size_Q), .r_mem_unsigned_Q(r_mem_unsigned_Q),
    .mem_flush(mem_flush), .dbus(bus),
    .r_wb_alu_Q(r_wb_alu_Q), .r_wb_memdat_Q(r_wb_memdat_Q), .r_wb_pc_Q(r_wb_pc_Q),
    .r_wb_rd_Q(r_wb_rd_Q), .r_wb_regwrite_Q(r_wb_regwrite_Q),
    .r_wb_rfwt_sel_Q(r_wb_rfwt_sel_Q), .r_wb_valid_Q(r_wb_valid_Q),
    .s_mem_stall(s_mem_stall), .mem_exc_valid(mem_exc_valid),
    .mem_exc_cause(mem_exc_cause), .mem_exc_addr(mem_exc_addr)
  );

  always #5 CLK = ~CLK;

  // Reference rules for the memory lanes, written from the ISA view of an access.
  function automatic logic [31:0] exp_load(int sz, int off, bit uns, logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * off);
    if (sz == 0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(int sz, int off);
    if (sz == 0) return 4'(1 << off);
    else if (sz == 1) return 4'(3 << off);
    else return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(int sz, logic [31:0] d);
    if (sz == 0) return (d % 256) * 32'h0101_0101;
    else if (sz == 1) return (d % 65536) * 32'h0001_0001;
    else return d;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    r_mem_valid = 1'b0;
    r_mem_memop_Q = 2'd0;
    mem_flush = 1'b0;
    bus.dbus_ack = 1'b0;
    bus.dbus_err = 1'b0;
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic rw);
    r_mem_valid = 1'b1;
    r_mem_memop_Q = op;
    r_mem_size_Q = sz;
    r_mem_unsigned_Q = uns;
    r_mem_alu_Q = alu;
    r_mem_rs2_Q = rs2;
    r_mem_pc_Q = $urandom();
    r_mem_rd_Q = 5'($urandom_range(1, 31));
    r_mem_regwrite_Q = rw;
    r_mem_rfwt_sel_Q = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.dbus_rdata = 32'd0;
    drive(2'd1, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 1'b1);
    #3;
    n_chk++;
    if ({bus.dbus_req, s_mem_stall, mem_exc_valid, r_wb_valid_Q, r_wb_regwrite_Q} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.dbus_req, s_mem_stall, mem_exc_valid, r_wb_valid_Q, r_wb_regwrite_Q});
    end
    n_chk++;
    if ({r_wb_alu_Q, r_wb_memdat_Q, r_wb_pc_Q, r_wb_rd_Q, r_wb_rfwt_sel_Q} !== 103'd0) begin
      n_fail++;
      $display("FAIL reset_wb: alu %h memdat %h pc %h expected zeros", r_wb_alu_Q, r_wb_memdat_Q, r_wb_pc_Q);
    end
    idle_inputs();
    step();
    RST = 1'b1;
    step();
  endtask

  task automatic test_alu();
    logic [31:0] alu, pc;
    logic [4:0] rd;
    logic rw;
    logic [1:0] sel;
    for (int i = 0; i < 8; i++) begin
      drive(2'((i == 5) ? 3 : 0), 2'd2, 1'b0, (i == 0) ? 32'h0000_1234 : $urandom(), 32'd0,
            (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      if (i == 0) r_mem_rd_Q = 5'd5;
      alu = r_mem_alu_Q; pc = r_mem_pc_Q; rd = r_mem_rd_Q; rw = r_mem_regwrite_Q; sel = r_mem_rfwt_sel_Q;
      @(negedge CLK);
      n_chk++;
      if ({bus.dbus_req, s_mem_stall} !== 2'b00) begin
        n_fail++;
        $display("FAIL alu_noreq[%0d]: got req/stall %b expected 00", i, {bus.dbus_req, s_mem_stall});
      end
      step();
      n_chk++;
      if ({r_wb_alu_Q, r_wb_pc_Q, r_wb_rd_Q, r_wb_regwrite_Q, r_wb_rfwt_sel_Q, r_wb_valid_Q, r_wb_memdat_Q}
          !== {alu, pc, rd, rw, sel, 1'b1, 32'd0}) begin
        n_fail++;
        $display("FAIL alu_wb[%0d]: got alu %h rd %0d rw %b v %b md %h expected alu %h rd %0d rw %b v 1 md 0",
                 i, r_wb_alu_Q, r_wb_rd_Q, r_wb_regwrite_Q, r_wb_valid_Q, r_wb_memdat_Q, alu, rd, rw);
      end
    end
    idle_inputs();
  endtask

  task automatic test_load_same_cycle();
    int sz, off;
    bit uns;
    logic [31:0] alu, rd_data, exp;
    for (int i = 0; i < 12; i++) begin
      if (i < 2) begin
        sz = 0; off = 3; uns = (i == 1); alu = 32'h0000_0103; rd_data = 32'h80FF_FF00;
        exp = (i == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
      end else begin
        sz = $urandom_range(0, 2);
        off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
        uns = 1'($urandom_range(0, 1));
        alu = ($urandom() & 32'hFFFF_FFFC) | 32'(off);
        rd_data = $urandom();
        exp = exp_load(sz, off, uns, rd_data);
      end
      drive(2'd1, 2'(sz), uns, alu, 32'd0, 1'b1);
      bus.dbus_ack = 1'b1;
      bus.dbus_rdata = rd_data;
      @(negedge CLK);
      n_chk++;
      if ({bus.dbus_req, bus.dbus_we, bus.dbus_addr, bus.dbus_be, s_mem_stall}
          !== {1'b1, 1'b0, alu & 32'hFFFF_FFFC, exp_be(sz, off), 1'b0}) begin
        n_fail++;
        $display("FAIL load_bus[%0d]: got req %b we %b addr %h be %b stall %b expected 1 0 %h %b 0", i,
                 bus.dbus_req, bus.dbus_we, bus.dbus_addr, bus.dbus_be, s_mem_stall,
                 alu & 32'hFFFF_FFFC, exp_be(sz, off));
      end
      step();
      n_chk++;
      if ({r_wb_memdat_Q, r_wb_valid_Q, r_wb_regwrite_Q} !== {exp, 2'b11}) begin
        n_fail++;
        $display("FAIL load_data[%0d]: got %h v %b rw %b expected %h v 1 rw 1", i,
                 r_wb_memdat_Q, r_wb_valid_Q, r_wb_regwrite_Q, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_store_wait();
    int sz, off, wt, stalls;
    logic [31:0] alu, data, exp_wd;
    logic [3:0] exp_b;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        sz = 1; off = 2; wt = 3; alu = 32'h0000_0202; data = 32'h0000_BEEF;
        exp_b = 4'b1100; exp_wd = 32'hBEEF_BEEF;
      end else begin
        sz = $urandom_range(0, 2);
        off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
        wt = $urandom_range(0, 2);
        alu = ($urandom() & 32'hFFFF_FFFC) | 32'(off);
        data = $urandom();
        exp_b = exp_be(sz, off); exp_wd = exp_wdata(sz, data);
      end
      drive(2'd2, 2'(sz), 1'b0, alu, data, 1'b0);
      stalls = 0;
      for (int c = 0; c <= wt; c++) begin
        bus.dbus_ack = (c == wt);
        @(negedge CLK);
        if (s_mem_stall === 1'b1) stalls++;
        n_chk++;
        if ({bus.dbus_req, bus.dbus_we, bus.dbus_addr, bus.dbus_be, bus.dbus_wdata}
            !== {2'b11, alu & 32'hFFFF_FFFC, exp_b, exp_wd}) begin
          n_fail++;
          $display("FAIL store_hold[%0d.%0d]: got req %b we %b addr %h be %b wd %h expected 1 1 %h %b %h", i, c,
                   bus.dbus_req, bus.dbus_we, bus.dbus_addr, bus.dbus_be, bus.dbus_wdata,
                   alu & 32'hFFFF_FFFC, exp_b, exp_wd);
        end
        step();
      end
      idle_inputs();
      n_chk++;
      if ({stalls, r_wb_valid_Q, r_wb_regwrite_Q, mem_exc_valid} !== {wt, 3'b100}) begin
        n_fail++;
        $display("FAIL store_done[%0d]: got stalls %0d v %b rw %b exc %b expected stalls %0d v 1 rw 0 exc 0",
                 i, stalls, r_wb_valid_Q, r_wb_regwrite_Q, mem_exc_valid, wt);
      end
    end
  endtask

  task automatic test_bus_error();
    int reqs;
    bit seen;
    logic [31:0] alu;
    logic [1:0] cause;
    // Load that is never acknowledged.
    alu = ($urandom() & 32'hFFFF_FFFC);
    drive(2'd1, 2'd2, 1'b0, alu, 32'd0, 1'b1);
    reqs = 0; seen = 1'b0; cause = 2'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (bus.dbus_req === 1'b1) reqs++;
      step();
      if (mem_exc_valid === 1'b1) begin
        seen = 1'b1;
        cause = mem_exc_cause;
        idle_inputs();
        break;
      end
    end
    n_chk++;
    if ({seen, reqs, cause, mem_exc_addr, r_wb_valid_Q, r_wb_regwrite_Q} !== {1'b1, TMO, 2'd2, alu, 2'b00}) begin
      n_fail++;
      $display("FAIL timeout: got seen %b reqs %0d cause %0d addr %h v %b rw %b expected 1 %0d 2 %h 0 0",
               seen, reqs, cause, mem_exc_addr, r_wb_valid_Q, r_wb_regwrite_Q, TMO, alu);
    end
    idle_inputs();
    step();
    n_chk++;
    if ({mem_exc_valid, bus.dbus_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_pulse: got exc %b req %b expected 0 0", mem_exc_valid, bus.dbus_req);
    end
    // Store acknowledged with an error after one wait cycle.
    alu = ($urandom() & 32'hFFFF_FFFC) | 32'd1;
    drive(2'd2, 2'd0, 1'b0, alu, $urandom(), 1'b1);
    step();
    bus.dbus_ack = 1'b1;
    bus.dbus_err = 1'b1;
    step();
    idle_inputs();
    n_chk++;
    if ({mem_exc_valid, mem_exc_cause, mem_exc_addr, r_wb_valid_Q, r_wb_regwrite_Q} !== {1'b1, 2'd3, alu, 2'b00}) begin
      n_fail++;
      $display("FAIL store_err: got exc %b cause %0d addr %h v %b rw %b expected 1 3 %h 0 0",
               mem_exc_valid, mem_exc_cause, mem_exc_addr, r_wb_valid_Q, r_wb_regwrite_Q, alu);
    end
    step();
  endtask

  task automatic test_misalign();
    logic [31:0] d;
    d = $urandom();
    drive(2'd1, 2'd2, 1'b0, 32'h0000_0101, 32'd0, 1'b1);
    bus.dbus_ack = 1'b1;
    bus.dbus_rdata = d;
    @(negedge CLK);
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    n_chk++;
    if ({bus.dbus_req, s_mem_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL mis_noreq: got req %b stall %b expected 0 0", bus.dbus_req, s_mem_stall);
    end
    step();
    n_chk++;
    if ({mem_exc_valid, mem_exc_cause, mem_exc_addr, r_wb_valid_Q} !== {1'b1, 2'd0, 32'h0000_0101, 1'b0}) begin
      n_fail++;
      $display("FAIL mis_lw: got exc %b cause %0d addr %h v %b expected 1 0 00000101 0",
               mem_exc_valid, mem_exc_cause, mem_exc_addr, r_wb_valid_Q);
    end
    drive(2'd2, 2'd1, 1'b0, 32'h0000_0203, 32'h1234_5678, 1'b0);
    step();
    n_chk++;
    if ({mem_exc_valid, mem_exc_cause, mem_exc_addr} !== {1'b1, 2'd1, 32'h0000_0203}) begin
      n_fail++;
      $display("FAIL mis_sh: got exc %b cause %0d addr %h expected 1 1 00000203",
               mem_exc_valid, mem_exc_cause, mem_exc_addr);
    end
`else
    n_chk++;
    if ({bus.dbus_req, bus.dbus_addr, bus.dbus_be} !== {1'b1, 32'h0000_0100, 4'hF}) begin
      n_fail++;
      $display("FAIL mis_lw_bus: got req %b addr %h be %b expected 1 00000100 1111",
               bus.dbus_req, bus.dbus_addr, bus.dbus_be);
    end
    step();
    n_chk++;
    if ({r_wb_memdat_Q, r_wb_valid_Q, mem_exc_valid} !== {d, 2'b10}) begin
      n_fail++;
      $display("FAIL mis_lw_data: got %h v %b exc %b expected %h 1 0", r_wb_memdat_Q, r_wb_valid_Q, mem_exc_valid, d);
    end
    drive(2'd2, 2'd1, 1'b0, 32'h0000_0203, 32'h1234_5678, 1'b0);
    @(negedge CLK);
    n_chk++;
    if ({bus.dbus_addr, bus.dbus_be, bus.dbus_wdata} !== {32'h0000_0200, 4'b1100, 32'h5678_5678}) begin
      n_fail++;
      $display("FAIL mis_sh_bus: got addr %h be %b wd %h expected 00000200 1100 56785678",
               bus.dbus_addr, bus.dbus_be, bus.dbus_wdata);
    end
    step();
    n_chk++;
    if ({mem_exc_valid, r_wb_valid_Q} !== 2'b01) begin
      n_fail++;
      $display("FAIL mis_sh_done: got exc %b v %b expected 0 1", mem_exc_valid, r_wb_valid_Q);
    end
`endif
    idle_inputs();
    step();
  endtask

  task automatic test_flush();
    drive(2'd1, 2'd2, 1'b0, 32'h0000_0040, 32'd0, 1'b1);
    mem_flush = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (bus.dbus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_req: got %b expected 0", bus.dbus_req);
    end
    step();
    n_chk++;
    if ({r_wb_valid_Q, r_wb_regwrite_Q} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_idle_wb: got v %b rw %b expected 0 0", r_wb_valid_Q, r_wb_regwrite_Q);
    end
    for (int e = 0; e < 2; e++) begin
      drive(2'd1, 2'd2, 1'b0, 32'h0000_0080, 32'd0, 1'b1);
      mem_flush = 1'b0;
      step();
      mem_flush = 1'b1;
      step();
      mem_flush = 1'b0;
      @(negedge CLK);
      n_chk++;
      if (bus.dbus_req !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_busy_hold[%0d]: got req %b expected 1", e, bus.dbus_req);
      end
      step();
      bus.dbus_ack = 1'b1;
      bus.dbus_err = 1'(e);
      bus.dbus_rdata = $urandom();
      step();
      idle_inputs();
      n_chk++;
      if ({r_wb_valid_Q, r_wb_regwrite_Q, mem_exc_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL flush_busy_done[%0d]: got v %b rw %b exc %b expected 0 0 0",
                 e, r_wb_valid_Q, r_wb_regwrite_Q, mem_exc_valid);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    drive(2'd1, 2'd2, 1'b0, 32'h0000_0300, 32'd0, 1'b1);
    step();
    @(negedge CLK);
    n_chk++;
    if ({bus.dbus_req, s_mem_stall} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_busy: got req %b stall %b expected 1 1", bus.dbus_req, s_mem_stall);
    end
    #2;
    RST = 1'b0;
    #1;
    n_chk++;
    if ({bus.dbus_req, s_mem_stall, r_wb_valid_Q} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_drop: got req %b stall %b v %b expected 0 0 0", bus.dbus_req, s_mem_stall, r_wb_valid_Q);
    end
    idle_inputs();
    step();
    RST = 1'b1;
    bus.dbus_ack = 1'b1;
    bus.dbus_rdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    n_chk++;
    if (bus.dbus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_lateack_req: got %b expected 0", bus.dbus_req);
    end
    step();
    idle_inputs();
    n_chk++;
    if ({r_wb_valid_Q, r_wb_regwrite_Q, mem_exc_valid, r_wb_memdat_Q} !== {3'b000, 32'd0}) begin
      n_fail++;
      $display("FAIL rstmid_lateack_wb: got v %b rw %b exc %b md %h expected 0 0 0 0",
               r_wb_valid_Q, r_wb_regwrite_Q, mem_exc_valid, r_wb_memdat_Q);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_same_cycle();
    test_store_wait();
    test_bus_error();
    test_misalign();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
